alu_control_sequencer: RTL and testbench

- Hardwired control unit that replaces hand-driven control steps on the datapath. For three-register ALU instructions it issues the fetch/execute micro-step strobes: T0-T2 fetch, T3-T5 execute.
- Sits beside the datapath. It reads IR_data_out and drives register in/out enables, MAR/MDR/IR/Y/Z strobes, Read, IncPC and ALU_Sel.
- Runs one instruction per start pulse, or free-runs while run is held high.

---
 rtl/alu_control_sequencer_pkg.sv | 57 +++++
 rtl/alu_control_sequencer_if.sv | 38 +++
 rtl/alu_control_sequencer_reg_onehot_decode.sv | 15 +
 rtl/alu_control_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_control_sequencer_pkg.sv
// Shared constants for the ALU control sequencer: state codes, opcodes,
// ALU select codes, IR field positions and the registered strobe bundle.
package cpu_ctrl_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] T0   = 3'd1;
    localparam logic [2:0] T1   = 3'd2;
    localparam logic [2:0] T2   = 3'd3;
    localparam logic [2:0] T3   = 3'd4;
    localparam logic [2:0] T4   = 3'd5;
    localparam logic [2:0] T5   = 3'd6;
    localparam logic [2:0] DONE = 3'd7;

    localparam logic [4:0] OP_ADD = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4;
    localparam logic [4:0] OP_AND = 5'd9;
    localparam logic [4:0] OP_OR  = 5'd10;

    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4;

    localparam int OPC_LSB = 27;
    localparam int RA_LSB  = 23;
    localparam int RB_LSB  = 19;
    localparam int RC_LSB  = 15;

    typedef struct packed {
        logic       PCout;
        logic       PCin;
        logic       IncPC;
        logic       MARin;
        logic       MDRin;
        logic       MDRout;
        logic       Read;
        logic       IRin;
        logic       Yin;
        logic       Zin;
        logic       Zlowout;
        logic       busy;
        logic       done;
        logic [4:0] alu_sel;
    } strobe_t;

    // Zero means the opcode is not supported by this sequencer.
    function automatic logic [4:0] alu_map(input logic [4:0] opcode);
        case (opcode)
            OP_ADD:  alu_map = ALU_ADD;
            OP_SUB:  alu_map = ALU_SUB;
            OP_AND:  alu_map = ALU_AND;
            OP_OR:   alu_map = ALU_OR;
            default: alu_map = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_sequencer_if.sv
// Control/datapath boundary of the ALU sequencer: requests and IR in,
// micro-step strobes and status out.
interface alu_control_sequencer_if #(
    parameter int NREGS = 16
);
    logic             start;
    logic             run;
    logic [31:0]      ir;
    logic             PCout;
    logic             PCin;
    logic             IncPC;
    logic             MARin;
    logic             MDRin;
    logic             MDRout;
    logic             Read;
    logic             IRin;
    logic             Yin;
    logic             Zin;
    logic             Zlowout;
    logic [NREGS-1:0] reg_in;
    logic [NREGS-1:0] reg_out;
    logic [4:0]       ALU_Sel;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        input  start, run, ir,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
               Zlowout, reg_in, reg_out, ALU_Sel, busy, done, illegal
    );

    modport slave (
        output start, run, ir,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
               Zlowout, reg_in, reg_out, ALU_Sel, busy, done, illegal
    );
endinterface

// File: rtl/alu_control_sequencer_reg_onehot_decode.sv
// 4-bit register index plus enable to a one-hot register enable vector.
module reg_onehot_decode #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en && (32'(idx) < NREGS)) begin
            onehot[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute sequencer for three-register ALU instructions.
// Outputs are registered from the next state so each strobe covers its whole state.
//
//   state | meaning
//   IDLE  | waiting for start
//   T0    | PC to MAR, increment PC into Z
//   T1    | Z to PC (first cycle), memory read held MEM_WAIT cycles
//   T2    | MDR to IR
//   T3    | decode; Rb to Y, or flag illegal and return to IDLE
//   T4    | Rc on bus, ALU result into Z
//   T5    | Z to Ra
//   DONE  | one-cycle done pulse, loop to T0 while run is high
module alu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int NREGS    = 16
) (
    input logic                     Clock,
    input logic                     clr,
    alu_control_sequencer_if.master bus
);
    logic [2:0]       state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic             illegal_q, illegal_d;
    strobe_t          str_q, str_d;
    logic [NREGS-1:0] reg_in_q, reg_in_d, reg_out_q, reg_out_d;
    logic [3:0]       in_idx, out_idx;
    logic             in_en, out_en;
    logic [4:0]       opcode, alu_code;
    logic             op_ok;
    logic [3:0]       ra, rb, rc;
    logic             unused_ir;

    assign opcode    = bus.ir[OPC_LSB +: 5];
    assign ra        = bus.ir[RA_LSB +: 4];
    assign rb        = bus.ir[RB_LSB +: 4];
    assign rc        = bus.ir[RC_LSB +: 4];
    assign unused_ir = ^bus.ir[RC_LSB-1:0];
    assign alu_code  = alu_map(opcode);
    assign op_ok     = (alu_code != 5'd0);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: if (bus.start) state_d = T0;
            T0: begin
                state_d = T1;
                wait_d  = 4'(MEM_WAIT - 1);
            end
            T1: begin
                if (wait_q == 4'd0) state_d = T2;
                else                wait_d  = wait_q - 4'd1;
            end
            T2:      state_d = T3;
            T3:      state_d = op_ok ? T4 : IDLE;
            T4:      state_d = T5;
            T5:      state_d = DONE;
            DONE:    state_d = bus.run ? T0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The IR must already hold the instruction when leaving T2: T3 strobes are decided then.
    always_comb begin
        str_d   = '0;
        in_en   = 1'b0;
        out_en  = 1'b0;
        in_idx  = ra;
        out_idx = rb;
        case (state_d)
            T0: begin
                str_d.PCout = 1'b1;
                str_d.MARin = 1'b1;
                str_d.IncPC = 1'b1;
                str_d.Zin   = 1'b1;
            end
            T1: begin
                str_d.Read  = 1'b1;
                str_d.MDRin = 1'b1;
                if (state_q == T0) begin
                    str_d.Zlowout = 1'b1;
                    str_d.PCin    = 1'b1;
                end
            end
            T2: begin
                str_d.MDRout = 1'b1;
                str_d.IRin   = 1'b1;
            end
            T3: begin
                if (op_ok) begin
                    out_en    = 1'b1;
                    str_d.Yin = 1'b1;
                end
            end
            T4: begin
                out_en        = 1'b1;
                out_idx       = rc;
                str_d.Zin     = 1'b1;
                str_d.alu_sel = alu_code;
            end
            T5: begin
                in_en         = 1'b1;
                str_d.Zlowout = 1'b1;
                str_d.alu_sel = str_q.alu_sel;
            end
            DONE:    str_d.done = 1'b1;
            default: ;
        endcase
        str_d.busy = (state_d != IDLE) && (state_d != DONE);
    end

    always_comb begin
        illegal_d = illegal_q;
        if ((state_q == IDLE) && bus.start) illegal_d = 1'b0;
        else if ((state_q == T3) && !op_ok) illegal_d = 1'b1;
    end

    reg_onehot_decode #(.NREGS(NREGS)) u_dec_in (
        .idx    (in_idx),
        .en     (in_en),
        .onehot (reg_in_d)
    );

    reg_onehot_decode #(.NREGS(NREGS)) u_dec_out (
        .idx    (out_idx),
        .en     (out_en),
        .onehot (reg_out_d)
    );

    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            wait_q    <= 4'd0;
            illegal_q <= 1'b0;
            str_q     <= '0;
            reg_in_q  <= '0;
            reg_out_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            str_q     <= str_d;
            reg_in_q  <= reg_in_d;
            reg_out_q <= reg_out_d;
        end
    end

    assign bus.PCout   = str_q.PCout;
    assign bus.PCin    = str_q.PCin;
    assign bus.IncPC   = str_q.IncPC;
    assign bus.MARin   = str_q.MARin;
    assign bus.MDRin   = str_q.MDRin;
    assign bus.MDRout  = str_q.MDRout;
    assign bus.Read    = str_q.Read;
    assign bus.IRin    = str_q.IRin;
    assign bus.Yin     = str_q.Yin;
    assign bus.Zin     = str_q.Zin;
    assign bus.Zlowout = str_q.Zlowout;
    assign bus.ALU_Sel = str_q.alu_sel;
    assign bus.busy    = str_q.busy;
    assign bus.done    = str_q.done;
    assign bus.reg_in  = reg_in_q;
    assign bus.reg_out = reg_out_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: two instances (MEM_WAIT 2 and 1) share stimulus
// and are compared every cycle against per-instruction expected output sequences.
module tb_alu_control_sequencer;

    typedef struct packed {
        logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, Zlowout;
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic [4:0]  alu;
        logic        busy, done, illegal;
    } snap_t;

    typedef struct {
        logic [31:0] ir;
        logic [4:0]  alu;
        logic [15:0] out_b;
        logic [15:0] out_c;
        logic [15:0] in_a;
        logic        ill;
        int          lat;
    } vec_t;

    logic        Clock = 1'b0;
    logic        clr   = 1'b0;
    logic        start = 1'b0;
    logic        run   = 1'b0;
    logic [31:0] ir    = 32'd0;
    logic        chk_en = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 Clock = ~Clock;

    alu_control_sequencer_if #(.NREGS(16)) bus0 ();
    alu_control_sequencer_if #(.NREGS(16)) bus1 ();

    assign bus0.start = start;
    assign bus0.run   = run;
    assign bus0.ir    = ir;
    assign bus1.start = start;
    assign bus1.run   = run;
    assign bus1.ir    = ir;

    alu_control_sequencer #(.MEM_WAIT(2), .NREGS(16)) dut0 (
        .Clock (Clock),
        .clr   (clr),
        .bus   (bus0)
    );

    alu_control_sequencer #(.MEM_WAIT(1), .NREGS(16)) dut1 (
        .Clock (Clock),
        .clr   (clr),
        .bus   (bus1)
    );

    snap_t s0, s1;
    assign s0 = {bus0.PCout, bus0.PCin, bus0.IncPC, bus0.MARin, bus0.MDRin, bus0.MDRout,
                 bus0.Read, bus0.IRin, bus0.Yin, bus0.Zin, bus0.Zlowout, bus0.reg_in,
                 bus0.reg_out, bus0.ALU_Sel, bus0.busy, bus0.done, bus0.illegal};
    assign s1 = {bus1.PCout, bus1.PCin, bus1.IncPC, bus1.MARin, bus1.MDRin, bus1.MDRout,
                 bus1.Read, bus1.IRin, bus1.Yin, bus1.Zin, bus1.Zlowout, bus1.reg_in,
                 bus1.reg_out, bus1.ALU_Sel, bus1.busy, bus1.done, bus1.illegal};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    snap_t cur [2] = '{default: '0};
    logic  ill [2] = '{default: 1'b0};
    int    mw  [2] = '{2, 1};
    snap_t q0 [$];
    snap_t q1 [$];

    function automatic logic [4:0] ref_alu(input logic [4:0] op);
        case (op)
            5'd3:    return 5'd1;
            5'd4:    return 5'd2;
            5'd9:    return 5'd3;
            5'd10:   return 5'd4;
            default: return 5'd0;
        endcase
    endfunction

    task automatic push(input int d, input snap_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop(input int d);
        if (d == 0) cur[0] = q0.pop_front();
        else        cur[1] = q1.pop_front();
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic snap_t idle_snap(input int d);
        snap_t e;
        e = '0;
        e.illegal = ill[d];
        return e;
    endfunction

    // Whole expected output sequence of one instruction, one entry per cycle.
    task automatic build(input int d);
        snap_t      b, e;
        logic [4:0] a;
        a = ref_alu(ir[31:27]);
        b = '0;
        b.busy = 1'b1;
        b.illegal = ill[d];
        e = b; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1; push(d, e);
        for (int i = 0; i < mw[d]; i++) begin
            e = b; e.Read = 1; e.MDRin = 1;
            if (i == 0) begin e.Zlowout = 1; e.PCin = 1; end
            push(d, e);
        end
        e = b; e.MDRout = 1; e.IRin = 1; push(d, e);
        if (a != 5'd0) begin
            e = b; e.Yin = 1; e.reg_out = 16'd1 << ir[22:19]; push(d, e);
            e = b; e.Zin = 1; e.reg_out = 16'd1 << ir[18:15]; e.alu = a; push(d, e);
            e = b; e.Zlowout = 1; e.reg_in = 16'd1 << ir[26:23]; e.alu = a; push(d, e);
            e = '0; e.done = 1; e.illegal = ill[d]; push(d, e);
        end else begin
            push(d, b);
        end
        pop(d);
    endtask

    task automatic model_step(input int d);
        if (qsize(d) != 0) pop(d);
        else if (cur[d].done) begin
            if (run) build(d);
            else     cur[d] = idle_snap(d);
        end else if (cur[d].busy) begin
            ill[d] = 1'b1;
            cur[d] = idle_snap(d);
        end else if (start) begin
            ill[d] = 1'b0;
            build(d);
        end else cur[d] = idle_snap(d);
    endtask

    always @(posedge Clock or negedge clr) begin
        if (!clr) begin
            q0.delete();
            q1.delete();
            for (int d = 0; d < 2; d++) begin
                cur[d] = '0;
                ill[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    function automatic logic both_idle();
        return (q0.size() == 0) && (q1.size() == 0) && !cur[0].busy && !cur[0].done &&
               !cur[1].busy && !cur[1].done;
    endfunction

    task automatic invariants(input string name, input snap_t s);
        check({name, "_excl"}, 64'((s.reg_in != 16'd0) && (s.reg_out != 16'd0)), 64'd0);
        check({name, "_in_1hot"}, 64'($countones(s.reg_in) <= 1), 64'd1);
        check({name, "_out_1hot"}, 64'($countones(s.reg_out) <= 1), 64'd1);
        check({name, "_read_t1"}, 64'(s.Read && !(s.busy && s.MDRin && !s.IRin)), 64'd0);
    endtask

    always @(negedge Clock) begin
        if (chk_en && clr) begin
            check("model0", 64'(s0), 64'(cur[0]));
            check("model1", 64'(s1), 64'(cur[1]));
            invariants("inv0", s0);
            invariants("inv1", s1);
        end
    end

    function automatic logic [31:0] rand_ir();
        logic [4:0]  ops [4];
        logic [31:0] r;
        ops = '{5'd3, 5'd4, 5'd9, 5'd10};
        r = $urandom;
        if ($urandom_range(0, 4) != 0) r[31:27] = ops[$urandom_range(0, 3)];
        return r;
    endfunction

    // ---------------- stimulus ----------------
    vec_t vecs [6];

    initial begin
        int          n, k, dn0, dn1, rd0, rd1;
        logic        got;
        logic [4:0]  o_alu;
        logic [15:0] o_b, o_c, o_in;
        logic        o_ill;

        vecs[0] = '{32'h4A920000, 5'd3, 16'h0004, 16'h0010, 16'h0020, 1'b0, 9};
        vecs[1] = '{32'h19100000, 5'd1, 16'h0004, 16'h0001, 16'h0004, 1'b0, 9};
        vecs[2] = '{32'hF8000000, 5'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 7};
        vecs[3] = '{{5'd4, 4'd7, 4'd15, 4'd1, 15'd0}, 5'd2, 16'h8000, 16'h0002, 16'h0080, 1'b0, 9};
        vecs[4] = '{{5'd10, 4'd0, 4'd3, 4'd3, 15'h1234}, 5'd4, 16'h0008, 16'h0008, 16'h0001, 1'b0, 9};
        vecs[5] = '{{5'd0, 4'd1, 4'd2, 4'd3, 15'd0}, 5'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 7};

        #23 clr = 1'b1;
        @(negedge Clock);
        check("reset_state0", 64'(s0), 64'd0);
        check("reset_state1", 64'(s1), 64'd0);
        chk_en = 1'b1;

        // directed table
        for (int v = 0; v < 6; v++) begin
            repeat (2) @(negedge Clock);
            ir = vecs[v].ir;
            start = 1'b1;
            n = 1; got = 0;
            o_alu = '0; o_b = '0; o_c = '0; o_in = '0; o_ill = 0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge Clock);
                start = 1'b0;
                n++;
                if (n == 2) check("ill_cleared_by_start", 64'(s0.illegal), 64'd0);
                if (s0.Yin) o_b = s0.reg_out;
                if (s0.Zin && s0.reg_out != 16'd0) begin o_c = s0.reg_out; o_alu = s0.alu; end
                if (s0.reg_in != 16'd0) o_in = s0.reg_in;
                if (s0.done || s0.illegal) begin got = 1; o_ill = s0.illegal; end
            end
            check($sformatf("vec%0d_latency", v), 64'(n), 64'(vecs[v].lat));
            check($sformatf("vec%0d_alu", v), 64'(o_alu), 64'(vecs[v].alu));
            check($sformatf("vec%0d_rb_out", v), 64'(o_b), 64'(vecs[v].out_b));
            check($sformatf("vec%0d_rc_out", v), 64'(o_c), 64'(vecs[v].out_c));
            check($sformatf("vec%0d_ra_in", v), 64'(o_in), 64'(vecs[v].in_a));
            check($sformatf("vec%0d_illegal", v), 64'(o_ill), 64'(vecs[v].ill));
        end

        // read length per MEM_WAIT
        repeat (3) @(negedge Clock);
        ir = 32'h4A920000;
        start = 1'b1;
        rd0 = 0; rd1 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            start = 1'b0;
            rd0 += int'(s0.Read);
            rd1 += int'(s1.Read);
        end
        check("read_cycles_mw2", 64'(rd0), 64'd2);
        check("read_cycles_mw1", 64'(rd1), 64'd1);

        // start during T3 is ignored
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        k = 0;
        while (!s0.Yin && k < 20) begin @(negedge Clock); k++; end
        check("t3_reached", 64'(s0.Yin), 64'd1);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        dn0 = 0;
        for (int c = 0; c < 20; c++) begin @(negedge Clock); dn0 += int'(s0.done); end
        check("start_ignored_dones", 64'(dn0), 64'd1);
        check("start_ignored_idle", 64'(s0.busy), 64'd0);

        // run mode: back-to-back instructions
        ir = 32'h19100000;
        run = 1'b1;
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        k = 0;
        while (!s0.done && k < 30) begin @(negedge Clock); k++; end
        check("run_first_done", 64'(s0.done), 64'd1);
        @(negedge Clock);
        check("run_no_idle", 64'({s0.busy, s0.PCout}), 64'd3);
        run = 1'b0;
        dn0 = 0;
        for (int c = 0; c < 30; c++) begin @(negedge Clock); dn0 += int'(s0.done); end
        check("run_second_done", 64'(dn0), 64'd1);

        // reset in the middle of T1 with Read high
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        k = 0;
        while (!s0.Read && k < 20) begin @(negedge Clock); k++; end
        check("reset_read_seen", 64'(s0.Read), 64'd1);
        #2 clr = 1'b0;
        #1;
        check("reset_async0", 64'(s0), 64'd0);
        check("reset_async1", 64'(s1), 64'd0);
        repeat (2) @(negedge Clock);
        clr = 1'b1;
        dn0 = 0; dn1 = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge Clock);
            dn0 += int'(s0.done);
            dn1 += int'(s1.done);
        end
        check("reset_no_done0", 64'(dn0), 64'd0);
        check("reset_no_done1", 64'(dn1), 64'd0);
        check("reset_idle0", 64'(s0.busy), 64'd0);

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge Clock);
            if (both_idle()) ir = rand_ir();
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) run = ~run;
        end
        start = 1'b0;
        run = 1'b0;
        repeat (40) @(negedge Clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
